// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : display_scheduler
//  Description : Round-robin sharing of a 4-digit BCD display among NUM_SRC
//                requesters. The granted value is converted to BCD with a
//                sequential shift-add-3 engine and held for DWELL cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module display_scheduler #(
    parameter int DATA_W  = 14,
    parameter int NUM_SRC = 4,
    parameter int DWELL   = 50000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC*DATA_W-1:0] value_flat,
    output logic [NUM_SRC-1:0]        grant,
    output logic [1:0]                src_idx,
    output logic [3:0]                bcd_ones,
    output logic [3:0]                bcd_tens,
    output logic [3:0]                bcd_hundreds,
    output logic [3:0]                bcd_thousands,
    output logic                      digits_valid,
    output logic                      new_frame,
    output logic                      overflow,
    output logic                      busy
);

    // Bit counter spans 0..DATA_W-1; dwell counter spans 0..DWELL-1.
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DATA_W-1:0] MAX_BCD    = DATA_W'(9999);
    localparam logic [1:0]        RR_INIT    = 2'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]        rr_last;
    logic [DATA_W-1:0] shift_reg;
    logic [15:0]       scratch;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DW_W-1:0]   dwell_cnt;

    logic              pick_found;
    logic [1:0]        pick_idx;
    logic [1:0]        cand;
    logic [DATA_W-1:0] picked_value;
    logic              sel_overflow;
    logic [15:0]       adj;
    logic [15:0]       next_scratch;
    logic [DATA_W-1:0] next_shift;
    logic              unused_carry;

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    function automatic logic [15:0] add3(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int n = 0; n < 4; n++) begin
            if (s[n*4 +: 4] >= 4'd5) begin
                r[n*4 +: 4] = s[n*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Round-robin search: first requester after rr_last, wrapping modulo 4.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = rr_last + 2'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign picked_value = value_flat[int'(pick_idx)*DATA_W +: DATA_W];

    // Value latched on entry to SELECT decides the overflow path there.
    assign sel_overflow = (shift_reg > MAX_BCD);

    // One shift-add-3 step; the top carry cannot be set for values <= 9999.
    assign adj = add3(scratch);
    assign {unused_carry, next_scratch} = {adj, shift_reg[DATA_W-1]};
    assign next_shift = {shift_reg[DATA_W-2:0], 1'b0};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                state_next = sel_overflow ? ST_HOLD : ST_CONVERT;
            end
            ST_CONVERT: begin
                if (bit_cnt == BIT_LAST) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (dwell_cnt == DWELL_LAST) begin
                    state_next = (|req) ? ST_SELECT : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Arbitration result, conversion datapath, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last       <= RR_INIT;
            shift_reg     <= '0;
            scratch       <= '0;
            bit_cnt       <= '0;
            dwell_cnt     <= '0;
            grant         <= '0;
            src_idx       <= 2'd0;
            bcd_ones      <= 4'd0;
            bcd_tens      <= 4'd0;
            bcd_hundreds  <= 4'd0;
            bcd_thousands <= 4'd0;
            digits_valid  <= 1'b0;
            new_frame     <= 1'b0;
            overflow      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            new_frame <= 1'b0;
            busy      <= (state_next != ST_IDLE);

            // The owner is chosen from req sampled on the edge entering SELECT.
            if (state_next == ST_SELECT && pick_found) begin
                grant     <= NUM_SRC'(1) << pick_idx;
                src_idx   <= pick_idx;
                rr_last   <= pick_idx;
                shift_reg <= picked_value;
            end

            case (state)
                ST_SELECT: begin
                    scratch   <= '0;
                    bit_cnt   <= '0;
                    dwell_cnt <= '0;
                    if (sel_overflow) begin
                        bcd_ones      <= 4'hF;
                        bcd_tens      <= 4'hF;
                        bcd_hundreds  <= 4'hF;
                        bcd_thousands <= 4'hF;
                        overflow      <= 1'b1;
                        new_frame     <= 1'b1;
                        digits_valid  <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    scratch   <= next_scratch;
                    shift_reg <= next_shift;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    // Digits change only once, when the final shift lands.
                    if (bit_cnt == BIT_LAST) begin
                        bcd_ones      <= next_scratch[3:0];
                        bcd_tens      <= next_scratch[7:4];
                        bcd_hundreds  <= next_scratch[11:8];
                        bcd_thousands <= next_scratch[15:12];
                        overflow      <= 1'b0;
                        new_frame     <= 1'b1;
                        digits_valid  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    dwell_cnt <= dwell_cnt + DW_W'(1);
                    if (dwell_cnt == DWELL_LAST && !(|req)) begin
                        grant <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scheduler
//  Description : Directed, table-driven bench for display_scheduler (DWELL=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_scheduler;

    localparam int DATA_W  = 14;
    localparam int NUM_SRC = 4;
    localparam int DWELL   = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_SRC-1:0]        req;
    logic [NUM_SRC*DATA_W-1:0] value_flat;
    logic [NUM_SRC-1:0]        grant;
    logic [1:0]                src_idx;
    logic [3:0]                bcd_ones;
    logic [3:0]                bcd_tens;
    logic [3:0]                bcd_hundreds;
    logic [3:0]                bcd_thousands;
    logic                      digits_valid;
    logic                      new_frame;
    logic                      overflow;
    logic                      busy;
    logic [15:0]               digits;

    assign digits = {bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones};

    display_scheduler #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .DWELL   (DWELL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .value_flat    (value_flat),
        .grant         (grant),
        .src_idx       (src_idx),
        .bcd_ones      (bcd_ones),
        .bcd_tens      (bcd_tens),
        .bcd_hundreds  (bcd_hundreds),
        .bcd_thousands (bcd_thousands),
        .digits_valid  (digits_valid),
        .new_frame     (new_frame),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  req;
        int          src;
        logic [13:0] val;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_idx;
        logic [15:0] exp_digits;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_val(input int idx, input logic [13:0] v);
        value_flat[idx*DATA_W +: DATA_W] = v;
    endtask

    // Advance until new_frame is seen or the budget runs out.
    task automatic wait_frame(input int budget, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (new_frame) begin
                lat = c;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    // Advance until busy drops; also counts stray new_frame pulses.
    task automatic wait_idle(input int budget, output int cyc, output int extra);
        cyc   = 0;
        extra = 0;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (new_frame) extra++;
            if (!busy) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            check($sformatf("rst%0d_grant", i), 32'(grant), 32'd0);
            check($sformatf("rst%0d_digits", i), 32'(digits), 32'h0000);
            check($sformatf("rst%0d_valid", i), 32'(digits_valid), 32'd0);
            check($sformatf("rst%0d_busy", i), 32'(busy), 32'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        bit ok;
        int cyc;
        int extra;
        logic [15:0] held;
        logic [3:0]  rr_grant [5];
        logic [15:0] rr_dig   [5];

        // req, src, value, grant, idx, digits, overflow, latency
        vt[0] = '{4'b0100, 2, 14'd1234,  4'b0100, 2'd2, 16'h1234, 1'b0, 16};
        vt[1] = '{4'b0001, 0, 14'd10000, 4'b0001, 2'd0, 16'hFFFF, 1'b1, 2};
        vt[2] = '{4'b0001, 0, 14'd5,     4'b0001, 2'd0, 16'h0005, 1'b0, 16};
        vt[3] = '{4'b1010, 1, 14'd9999,  4'b0010, 2'd1, 16'h9999, 1'b0, 16};
        vt[4] = '{4'b1010, 3, 14'd8,     4'b1000, 2'd3, 16'h0008, 1'b0, 16};
        vt[5] = '{4'b1111, 0, 14'd0,     4'b0001, 2'd0, 16'h0000, 1'b0, 16};

        req        = 4'b1111;
        value_flat = {4{14'd4321}};
        do_reset(3);
        req = 4'b0000;
        step();

        // Table of single frames, each started from IDLE.
        for (int i = 0; i < 6; i++) begin
            value_flat = {4{14'd3333}};
            set_val(vt[i].src, vt[i].val);
            req = vt[i].req;
            wait_frame(40, lat, ok);
            check($sformatf("v%0d_frame_seen", i), 32'(ok), 32'd1);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vt[i].exp_grant));
            check($sformatf("v%0d_src_idx", i), 32'(src_idx), 32'(vt[i].exp_idx));
            check($sformatf("v%0d_digits", i), 32'(digits), 32'(vt[i].exp_digits));
            check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vt[i].exp_ovf));
            check($sformatf("v%0d_valid", i), 32'(digits_valid), 32'd1);
            req = 4'b0000;
            wait_idle(40, cyc, extra);
            check($sformatf("v%0d_hold_len", i), 32'(cyc), 32'(DWELL));
            check($sformatf("v%0d_extra_frames", i), 32'(extra), 32'd0);
            check($sformatf("v%0d_idle_grant", i), 32'(grant), 32'd0);
            check($sformatf("v%0d_idle_digits", i), 32'(digits), 32'(vt[i].exp_digits));
        end

        // Continuous round-robin from a fresh reset.
        do_reset(1);
        rr_grant[0] = 4'b0001; rr_dig[0] = 16'h0000;
        rr_grant[1] = 4'b0010; rr_dig[1] = 16'h9999;
        rr_grant[2] = 4'b0100; rr_dig[2] = 16'h0042;
        rr_grant[3] = 4'b1000; rr_dig[3] = 16'h0007;
        rr_grant[4] = 4'b0001; rr_dig[4] = 16'h0000;
        value_flat = {14'd7, 14'd42, 14'd9999, 14'd0};
        req        = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_frame(40, lat, ok);
            check($sformatf("rr%0d_frame_seen", f), 32'(ok), 32'd1);
            check($sformatf("rr%0d_spacing", f), 32'(lat), (f == 0) ? 32'd16 : 32'd23);
            check($sformatf("rr%0d_grant", f), 32'(grant), 32'(rr_grant[f]));
            check($sformatf("rr%0d_digits", f), 32'(digits), 32'(rr_dig[f]));
        end
        req = 4'b0000;
        wait_idle(40, cyc, extra);
        check("rr_idle_grant", 32'(grant), 32'd0);

        // Value and req change after SELECT must not affect the frame.
        held = digits;
        value_flat = {4{14'd3333}};
        set_val(1, 14'd500);
        req = 4'b0010;
        step();
        check("mid_select_grant", 32'(grant), 32'b0010);
        step();
        step();
        req = 4'b0000;
        set_val(1, 14'd77);
        step();
        check("mid_convert_no_flicker", 32'(digits), 32'(held));
        check("mid_convert_no_frame", 32'(new_frame), 32'd0);
        wait_frame(40, lat, ok);
        check("mid_frame_seen", 32'(ok), 32'd1);
        check("mid_digits", 32'(digits), 32'h0500);
        wait_idle(40, cyc, extra);
        check("mid_hold_len", 32'(cyc), 32'(DWELL));
        check("mid_idle_grant", 32'(grant), 32'd0);
        check("mid_idle_digits", 32'(digits), 32'h0500);

        // Reset during CONVERT discards the conversion and the arbiter pointer.
        set_val(2, 14'd1234);
        req = 4'b0100;
        step();
        check("rc_select_grant", 32'(grant), 32'b0100);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rc_grant", 32'(grant), 32'd0);
        check("rc_src_idx", 32'(src_idx), 32'd0);
        check("rc_digits", 32'(digits), 32'h0000);
        check("rc_valid", 32'(digits_valid), 32'd0);
        check("rc_busy", 32'(busy), 32'd0);
        check("rc_overflow", 32'(overflow), 32'd0);
        check("rc_new_frame", 32'(new_frame), 32'd0);
        value_flat = {14'd3333, 14'd3333, 14'd3333, 14'd321};
        set_val(1, 14'd321);
        set_val(3, 14'd888);
        req = 4'b1010;
        step();
        check("rc_first_grant", 32'(grant), 32'b0010);
        check("rc_first_idx", 32'(src_idx), 32'd1);
        wait_frame(40, lat, ok);
        check("rc_frame_seen", 32'(ok), 32'd1);
        check("rc_frame_lat", 32'(lat), 32'd15);
        check("rc_frame_digits", 32'(digits), 32'h0321);
        req = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
